// File: rtl/nn_req_scheduler_if.sv
// nn_req_scheduler_if: request, response and NN-side signals of the scheduler.
// Rev 1.0
`default_nettype none

interface nn_req_scheduler_if #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 17
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [4*IN_W-1:0]     req0_x;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [4*IN_W-1:0]     req1_x;
  logic [IN_W-1:0]       nn_x0;
  logic [IN_W-1:0]       nn_x1;
  logic [IN_W-1:0]       nn_x2;
  logic [IN_W-1:0]       nn_x3;
  logic [OUT_W-1:0]      nn_y0;
  logic [OUT_W-1:0]      nn_y1;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [OUT_W-1:0]      rsp_y0;
  logic [OUT_W-1:0]      rsp_y1;

  modport slave (
    input  req0_valid, req0_x, req1_valid, req1_x, nn_y0, nn_y1, rsp_ready,
    output req0_ready, req1_ready, nn_x0, nn_x1, nn_x2, nn_x3,
           rsp_valid, rsp_id, rsp_y0, rsp_y1
  );

  modport master (
    output req0_valid, req0_x, req1_valid, req1_x, nn_y0, nn_y1, rsp_ready,
    input  req0_ready, req1_ready, nn_x0, nn_x1, nn_x2, nn_x3,
           rsp_valid, rsp_id, rsp_y0, rsp_y1
  );
endinterface

`default_nettype wire

// File: rtl/nn_req_scheduler.sv
// nn_req_scheduler: round-robin sequencer sharing one NN between two requesters.
// Rev 1.0
`default_nettype none

module nn_req_scheduler #(
  parameter int IN_W    = 9,
  parameter int OUT_W   = 17,
  parameter int LATENCY = 24,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nn_req_scheduler_if.slave    bus,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_done_count
);

  localparam logic [7:0] C_LAST = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_grant;
  logic [7:0]         r_cnt;
  logic [IN_W-1:0]    r_nn_x0, r_nn_x1, r_nn_x2, r_nn_x3;
  logic [OUT_W-1:0]   r_rsp_y0, r_rsp_y1;
  logic               r_rsp_id;
  logic               r_rsp_valid;
  logic [CNT_W-1:0]   r_done_count;

  logic               w_grant_v;
  logic               w_grant;
  logic               w_accept;
  logic               w_capture;
  logic               w_rsp_fire;
  logic [4*IN_W-1:0]  w_sel_x;

  // Contention goes to whoever was not served last.
  always_comb begin
    w_grant_v = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = bus.req1_valid;
    end
    w_sel_x = w_grant ? bus.req1_x : bus.req0_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    w_rsp_fire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_v) begin
          bus.req0_ready = ~w_grant;
          bus.req1_ready = w_grant;
          w_accept       = 1'b1;
          w_state_nxt    = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == C_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_nn_x0      <= '0;
      r_nn_x1      <= '0;
      r_nn_x2      <= '0;
      r_nn_x3      <= '0;
      r_rsp_y0     <= '0;
      r_rsp_y1     <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_done_count <= '0;
    end else begin
      if (w_accept) begin
        r_nn_x0      <= w_sel_x[0*IN_W +: IN_W];
        r_nn_x1      <= w_sel_x[1*IN_W +: IN_W];
        r_nn_x2      <= w_sel_x[2*IN_W +: IN_W];
        r_nn_x3      <= w_sel_x[3*IN_W +: IN_W];
        r_rsp_id     <= w_grant;
        r_last_grant <= w_grant;
        r_cnt        <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) begin
        r_rsp_y0    <= bus.nn_y0;
        r_rsp_y1    <= bus.nn_y1;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_fire) begin
        r_rsp_valid  <= 1'b0;
        r_done_count <= r_done_count + 1'b1;
      end
    end
  end

  assign bus.nn_x0     = r_nn_x0;
  assign bus.nn_x1     = r_nn_x1;
  assign bus.nn_x2     = r_nn_x2;
  assign bus.nn_x3     = r_nn_x3;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_y0    = r_rsp_y0;
  assign bus.rsp_y1    = r_rsp_y1;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done_count  = r_done_count;

endmodule

`default_nettype wire

// File: doc/nn_req_scheduler.md
Name: nn_req_scheduler

Overview:
- Sequencer and round-robin arbiter that shares one FeedForwardNN instance between two requesters.
- Accepts a 4-element signed input vector from either requester over a valid/ready handshake and drives it onto the NN inputs.
- Holds the vector for a fixed settle latency, then captures y0/y1 and returns them, tagged with the requester id, over a valid/ready response channel.
- Only one vector is in flight at a time.

Parameters:
- IN_W, 9, width of each signed NN input element x0..x3.
- OUT_W, 17, width of each signed NN output y0/y1.
- LATENCY, 24, clock cycles the NN inputs are held stable before outputs are sampled; legal range 1..255.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a vector.
- req0_ready  out  1  scheduler accepts from requester 0 this cycle.
- req0_x  in  4*IN_W  packed vector, {x3,x2,x1,x0}; x0 in the LSBs.
- req1_valid, req1_ready, req1_x  as above, for requester 1.
- nn_x0, nn_x1, nn_x2, nn_x3  out  IN_W each  registered NN inputs.
- nn_y0, nn_y1  in  OUT_W each  NN outputs.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_y0, rsp_y1  out  OUT_W each  captured NN results, signed.
- busy  out  1  high in any state except IDLE.
- done_count  out  CNT_W  number of completed response handshakes.

Behaviour:
- Reset (RST=0, asynchronous), effective immediately regardless of state:
  - state=IDLE.
  - nn_x*, rsp_y*, rsp_id, done_count, wait counter = 0.
  - rsp_valid=0.
  - Round-robin pointer last_grant=1, so requester 0 wins first.
- Reset mid-operation aborts the transaction; no response is ever produced for it.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - Grant is combinational from the valid inputs and last_grant.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester != last_grant is granted.
  - req<g>_ready=1 for the granted requester only; the other ready is 0.
  - On the handshake edge:
    - nn_x0..3 <= slices of req<g>_x.
    - rsp_id <= g; last_grant <= g.
    - counter <= 0; state -> RUN.
  - If no valid is high, both readys are 0 and the state holds.
- RUN:
  - Both readys are 0; nn_x* are held stable.
  - The counter increments each cycle.
  - When counter == LATENCY-1: rsp_y0 <= nn_y0, rsp_y1 <= nn_y1, rsp_valid <= 1, state -> RESP.
  - The first vector is accepted on edge T. Response data is registered on edge T+LATENCY, and rsp_valid is high from that edge onward.
- RESP:
  - rsp_valid=1. rsp_y*, rsp_id and nn_x* are held until the handshake.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, done_count <= done_count+1 (wraps to 0 at 2^CNT_W), state -> IDLE.
  - Back-pressure of any duration is legal.
- Throughput: at most one transaction per LATENCY+2 cycles (one IDLE accept cycle, LATENCY RUN cycles, at least one RESP cycle). A new request is never accepted in the same cycle as a response handshake.
- After completion, nn_x* keep their last value (not cleared).
- rsp_y* are pass-through captures; no saturation or width change.
- A requester that drops valid before being granted is simply not served. Requesters must hold valid and data stable until ready.
- LATENCY=1: the capture happens on the first RUN cycle.

Test Plan:
- Reset then single request: req0_x={x3=4,x2=-3,x1=2,x0=1}, valid at cycle 2 → req0_ready=1 that cycle; nn_x0..3 = 1,2,-3,4 next edge; rsp_valid rises exactly LATENCY(24) cycles after accept. rsp_y* equal the NN model outputs, rsp_id=0, done_count=1 after rsp_ready.
- Both valid continuously, 4 transactions → grants 0,1,0,1; rsp_id sequence 0,1,0,1; never two readys high together.
- Back-pressure: rsp_ready=0 for 50 cycles in RESP → rsp_valid, rsp_y*, nn_x* stable; req readys 0; handshake on the first rsp_ready=1 cycle.
- Reset asserted at RUN count 10 → all outputs 0 asynchronously, busy=0, no response. After release, the next request is served from requester 0 first.
- Extremes: x0..x3 = -256 and 255 → nn_x* sign-correct, rsp_y* match the model bit-exact.
- CNT_W=2 build, 5 transactions → done_count sequence 1,2,3,0,1.
